// File: rtl/iomem_mem_bridge_pkg.sv
// Shared types and constants for the iomem-to-word-memory bridge.
package iomem_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WB    = 3'd3,
        ST_DELAY = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    localparam logic [3:0] WSTRB_READ = 4'h0;
    localparam logic [3:0] WSTRB_FULL = 4'hF;

    // Wait-state counter covers LATENCY 0..255.
    localparam int CNT_W = $clog2(256);
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/iomem_mem_bridge_byte_merge.sv
// Combinational byte merge for read-modify-write: byte i comes from the
// new word when wstrb[i] is set, otherwise from the old memory word.
module iomem_byte_merge
    import iomem_bridge_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_word_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] merged_o
);

    // Select each byte lane independently from old or new data.
    always_comb begin
        merged_o = old_word_i;
        for (int i = 0; i < 4; i++) begin
            if (wstrb_i[i]) begin
                merged_o[8*i +: 8] = new_word_i[8*i +: 8];
            end else begin
                merged_o[8*i +: 8] = old_word_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/iomem_mem_bridge.sv
// iomem bus responder in front of a single-port word memory. Serves reads,
// full-word writes, and partial writes via read-modify-write, then pulses
// iomem_ready_o after LATENCY extra wait cycles.
// Optional feature: define IOMEM_BRIDGE_RANGE_CHECK_EN to reject accesses
// outside [BASE_ADDR, BASE_ADDR + 4*MEM_DEPTH) with no memory command,
// ERR_DATA as read data and a sticky err_o.
module iomem_mem_bridge
    import iomem_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [31:0] MEM_DEPTH = 32'h0000_1000,
    parameter int unsigned LATENCY   = 0,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        iomem_valid_i,
    input  logic [3:0]  iomem_wstrb_i,
    input  logic [31:0] iomem_addr_i,
    input  logic [31:0] iomem_wdata_i,
    output logic        iomem_ready_o,
    output logic [31:0] iomem_rdata_o,
    output logic        mem_cmd_valid_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

`ifdef IOMEM_BRIDGE_RANGE_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    // 34-bit window bounds so BASE_ADDR + 4*MEM_DEPTH cannot wrap.
    localparam logic [33:0] WIN_LO  = {2'b00, BASE_ADDR};
    localparam logic [33:0] WIN_HI  = WIN_LO + {MEM_DEPTH, 2'b00};
    localparam cnt_t        LAT_CNT = cnt_t'(LATENCY);
    // After the memory work is done: wait states first, or straight to ready.
    localparam state_t      POST_ST = (LATENCY == 32'd0) ? ST_RESP : ST_DELAY;

    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        ok_q, ok_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        err_q, err_d;
    logic        in_range_s;
    logic        access_ok_s;
    logic [31:0] merged_s;

    assign in_range_s  = ({2'b00, iomem_addr_i} >= WIN_LO) && ({2'b00, iomem_addr_i} < WIN_HI);
    assign access_ok_s = in_range_s | ~CHECK_EN;

    iomem_byte_merge u_merge (
        .old_word_i (mem_rdata_i),
        .new_word_i (wdata_q),
        .wstrb_i    (wstrb_q),
        .merged_o   (merged_s)
    );

    // State register and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= WSTRB_READ;
            ok_q        <= 1'b0;
            rdata_q     <= 32'h0;
            ready_q     <= 1'b0;
            resp_data_q <= 32'h0;
            cmd_valid_q <= 1'b0;
            wr_en_q     <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            ok_q        <= ok_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            resp_data_q <= resp_data_d;
            cmd_valid_q <= cmd_valid_d;
            wr_en_q     <= wr_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic; memory commands are prepared one cycle ahead so they
    // appear registered during CMD and WB.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        ok_d        = ok_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cmd_valid_d = 1'b0;
        wr_en_d     = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (iomem_valid_i) begin
                    addr_d  = {iomem_addr_i[31:2], 2'b00};
                    wdata_d = iomem_wdata_i;
                    wstrb_d = iomem_wstrb_i;
                    ok_d    = access_ok_s;
                    state_d = ST_CMD;
                    if (access_ok_s) begin
                        cmd_valid_d = 1'b1;
                        wr_en_d     = (iomem_wstrb_i == WSTRB_FULL);
                        mem_addr_d  = {iomem_addr_i[31:2], 2'b00};
                        mem_wdata_d = iomem_wdata_i;
                    end else begin
                        cmd_valid_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (!ok_q) begin
                    err_d   = 1'b1;
                    rdata_d = (wstrb_q == WSTRB_READ) ? ERR_DATA : 32'h0;
                    state_d = POST_ST;
                    cnt_d   = LAT_CNT;
                end else if (wstrb_q == WSTRB_FULL) begin
                    state_d = POST_ST;
                    cnt_d   = LAT_CNT;
                end else begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                if (wstrb_q == WSTRB_READ) begin
                    rdata_d = mem_rdata_i;
                    state_d = POST_ST;
                    cnt_d   = LAT_CNT;
                end else begin
                    rdata_d     = merged_s;
                    state_d     = ST_WB;
                    cmd_valid_d = 1'b1;
                    wr_en_d     = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = merged_s;
                end
            end
            ST_WB: begin
                state_d = POST_ST;
                cnt_d   = LAT_CNT;
            end
            ST_DELAY: begin
                if (cnt_q <= cnt_t'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q - cnt_t'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d     = (state_d == ST_RESP);
        resp_data_d = ((state_d == ST_RESP) && (wstrb_q == WSTRB_READ)) ? rdata_d : 32'h0;
    end

    assign iomem_ready_o   = ready_q;
    assign iomem_rdata_o   = resp_data_q;
    assign mem_cmd_valid_o = cmd_valid_q;
    assign mem_wr_en_o     = wr_en_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_iomem_mem_bridge.sv
// Scoreboard bench for iomem_mem_bridge: two instances (LATENCY 0 and 5),
// each with its own word memory, reference memory, driver and monitor.
module tb_iomem_mem_bridge;
    import iomem_bridge_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          start;
    } exp_t;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 8) return 32'hAABB_CCDD;
        return (32'(idx) * 32'h0101_0107) ^ 32'h5A5A_3C3C;
    endfunction

    // Reference write rule expressed as a byte mask.
    function automatic logic [31:0] apply_write(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    function automatic int exp_latency(input logic [3:0] s, input bit ok, input int lat);
        if (!ok || s == 4'hF) return 2 + lat;
        if (s == 4'h0) return 3 + lat;
        return 4 + lat;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int unsigned LAT = (g == 0) ? 0 : 5;

        logic        rst, valid, ready, cmd_valid, wr_en, err;
        logic [3:0]  wstrb;
        logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
        logic [31:0] mem [0:63];
        logic [31:0] ref_mem [0:63];
        logic [31:0] rd_q;
        int          n_cmd = 0;
        int          exp_cmd = 0;
        exp_t        sbq[$];
        exp_t        mon_e;
        logic        done = 1'b0;

        iomem_mem_bridge #(.LATENCY(LAT)) u_dut (
            .clk_i           (clk),
            .rst_i           (rst),
            .iomem_valid_i   (valid),
            .iomem_wstrb_i   (wstrb),
            .iomem_addr_i    (addr),
            .iomem_wdata_i   (wdata),
            .iomem_ready_o   (ready),
            .iomem_rdata_o   (rdata),
            .mem_cmd_valid_o (cmd_valid),
            .mem_wr_en_o     (wr_en),
            .mem_addr_o      (mem_addr),
            .mem_wdata_o     (mem_wdata),
            .mem_rdata_i     (mem_rdata),
            .err_o           (err)
        );

        assign mem_rdata = rd_q;

        // Word memory: read data appears the cycle after a read command.
        always @(posedge clk) begin
            if (cyc == 0) begin
                for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            end else if (cmd_valid) begin
                n_cmd <= n_cmd + 1;
                if (wr_en) mem[mem_addr[7:2]] <= mem_wdata;
                else rd_q <= mem[mem_addr[7:2]];
            end
        end

        // Monitor: every ready pulse must match the oldest outstanding request.
        always @(negedge clk) begin
            if (ready) begin
                if (sbq.size() == 0) begin
                    check($sformatf("L%0d unexpected_ready", LAT), {31'h0, ready}, 32'h0);
                end else begin
                    mon_e = sbq.pop_front();
                    check($sformatf("L%0d rdata", LAT), rdata, mon_e.data);
                    check($sformatf("L%0d ready_cycle", LAT), 32'(cyc - mon_e.start), 32'(mon_e.lat));
                end
            end
            if (cmd_valid) begin
                check($sformatf("L%0d mem_addr_window", LAT),
                      {mem_addr[31:8], 6'h00, mem_addr[1:0]}, 32'h4000_0000);
            end
        end

        task automatic check_reset_outputs(input string tag);
            check($sformatf("L%0d %s ready", LAT, tag), {31'h0, ready}, 32'h0);
            check($sformatf("L%0d %s rdata", LAT, tag), rdata, 32'h0);
            check($sformatf("L%0d %s cmd_valid", LAT, tag), {31'h0, cmd_valid}, 32'h0);
            check($sformatf("L%0d %s wr_en", LAT, tag), {31'h0, wr_en}, 32'h0);
            check($sformatf("L%0d %s mem_addr", LAT, tag), mem_addr, 32'h0);
            check($sformatf("L%0d %s mem_wdata", LAT, tag), mem_wdata, 32'h0);
            check($sformatf("L%0d %s err", LAT, tag), {31'h0, err}, 32'h0);
        endtask

        // Issue one request starting in an IDLE cycle and wait for its ready.
        task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                             input bit drop);
            bit          ok;
            bit          got;
            int          w;
            logic [31:0] expd;
`ifdef IOMEM_BRIDGE_RANGE_CHECK_EN
            ok = (a >= 32'h4000_0000) && (a < 32'h4000_4000);
`else
            ok = 1'b1;
`endif
            w = int'(a[7:2]);
            if (!ok) begin
                expd = (s == 4'h0) ? 32'hDEAD_BEEF : 32'h0;
            end else if (s == 4'h0) begin
                expd = ref_mem[w];
            end else begin
                ref_mem[w] = apply_write(ref_mem[w], d, s);
                expd = 32'h0;
            end
            if (ok) exp_cmd += ((s == 4'h0) || (s == 4'hF)) ? 1 : 2;
            sbq.push_back('{data: expd, lat: exp_latency(s, ok, LAT), start: cyc});
            valid = 1'b1;
            wstrb = s;
            addr  = a;
            wdata = d;
            @(posedge clk);
            #1;
            if (drop) valid = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (ready) got = 1'b1;
            end
            if (!got) check($sformatf("L%0d ready_timeout", LAT), 32'h0, 32'h1);
            @(posedge clk);
            #1;
        endtask

        task automatic random_burst(input int n);
            logic [3:0]  s;
            logic [31:0] a;
            for (int t = 0; t < n; t++) begin
                case ($urandom_range(0, 2))
                    0: s = 4'h0;
                    1: s = 4'hF;
                    default: s = 4'($urandom_range(1, 14));
                endcase
                a = 32'h4000_0000 + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) begin
                    valid = 1'b0;
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                issue(s, a, $urandom, ($urandom_range(0, 7) == 0));
            end
        endtask

        // Driver: directed cases, random traffic, mid-transaction reset, final audit.
        initial begin
            rst = 1'b1; valid = 1'b0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
            repeat (3) @(posedge clk);
            #1;
            check_reset_outputs("reset");
            rst = 1'b0;
            @(posedge clk);
            #1;

            issue(4'hF, 32'h4000_0010, 32'h1234_5678, 1'b0);
            issue(4'h0, 32'h4000_0010, 32'h0, 1'b0);
            issue(4'b0010, 32'h4000_0020, 32'h0000_EE00, 1'b0);
            issue(4'h0, 32'h4000_0020, 32'h0, 1'b0);
            random_burst(50);

`ifdef IOMEM_BRIDGE_RANGE_CHECK_EN
            issue(4'h0, 32'h3FFF_FFFC, 32'h0, 1'b0);
            issue(4'hF, 32'h4000_4000, 32'h1111_2222, 1'b0);
            check($sformatf("L%0d err_set", LAT), {31'h0, err}, 32'h1);
            issue(4'h0, 32'h4000_0004, 32'h0, 1'b0);
            check($sformatf("L%0d err_sticky", LAT), {31'h0, err}, 32'h1);
`else
            check($sformatf("L%0d err_tied", LAT), {31'h0, err}, 32'h0);
`endif

            // Partial write interrupted by reset during its capture cycle.
            valid = 1'b1; wstrb = 4'b1000; addr = 32'h4000_0030; wdata = 32'h7700_0000;
            exp_cmd += 1;
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            rst = 1'b1;
            valid = 1'b0;
            @(posedge clk);
            #1;
            check_reset_outputs("mid_reset");
            @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            issue(4'h0, 32'h4000_0030, 32'h0, 1'b0);
            random_burst(10);

            valid = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("L%0d outstanding", LAT), 32'(sbq.size()), 32'h0);
            check($sformatf("L%0d mem_cmd_count", LAT), 32'(n_cmd), 32'(exp_cmd));
            for (int i = 0; i < 64; i++) begin
                check($sformatf("L%0d mem_word_%0d", LAT, i), mem[i], ref_mem[i]);
            end
            done = 1'b1;
        end
    end

    initial begin
        for (int k = 0; k < 60000 && !(inst[0].done && inst[1].done); k++) @(posedge clk);
        check("all_done", {30'h0, inst[1].done, inst[0].done}, 32'h3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
